// File: rtl/simd_pkg.sv
// Purpose: shared opcode encoding for the SIMD reservation-station cluster.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Ports: none. Optional opcodes 101/110 are only live with SIMD_ALU_SAT_EN.
package simd_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_OR   = 3'b010,
    OP_AND  = 3'b011,
    OP_XOR  = 3'b100,
    OP_SADD = 3'b101,
    OP_SSUB = 3'b110,
    OP_RSVD = 3'b111
  } alu_op_e;

endpackage

// File: rtl/simd_rs_lane.sv
// Purpose: one in-order reservation station lane with its ALU and result registers.
// Latency: wake at edge E -> res_valid after edge E+1; at most one retire per cycle.
// Backpressure: none internally; the parent must only assert alloc while count < RS_DEPTH.
// Ports: alloc/alloc_* write the tail slot; wake/wake_idx mark a slot ready;
//        tail/count expose occupancy; res_valid/res_data/res_idx are the registered retire outputs.
// Config: SIMD_ALU_SAT_EN turns opcodes 101/110 into saturating add/subtract.
module simd_rs_lane import simd_pkg::*; #(
  parameter int RS_DEPTH = 4,
  parameter int DATA_W   = 8,
  parameter int IDX_W    = $clog2(RS_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic [OP_W-1:0]   alloc_op,
  input  logic [DATA_W-1:0] alloc_a,
  input  logic [DATA_W-1:0] alloc_b,
  input  logic              wake,
  input  logic [IDX_W-1:0]  wake_idx,
  output logic [IDX_W-1:0]  tail,
  output logic [IDX_W:0]    count,
  output logic              res_valid,
  output logic [DATA_W:0]   res_data,
  output logic [IDX_W-1:0]  res_idx
);

  localparam int CNT_W = IDX_W + 1;

  logic [RS_DEPTH-1:0] e_vld;
  logic [RS_DEPTH-1:0] e_rdy;
  logic [OP_W-1:0]     e_op [RS_DEPTH];
  logic [DATA_W-1:0]   e_a  [RS_DEPTH];
  logic [DATA_W-1:0]   e_b  [RS_DEPTH];
  logic [IDX_W-1:0]    head;
  logic                retire;

  // Only the head may execute, so a stalled head blocks younger ready entries.
  assign retire = e_vld[head] && e_rdy[head];

  function automatic logic [DATA_W:0] alu(input logic [OP_W-1:0] op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [DATA_W:0] xa;
    logic [DATA_W:0] xb;
    logic [DATA_W:0] sum;
    logic [DATA_W:0] dif;
    xa  = {1'b0, a};
    xb  = {1'b0, b};
    sum = xa + xb;
    dif = xa - xb;   // MSB doubles as the borrow (a < b)
    alu = '0;
    case (alu_op_e'(op))
      OP_ADD:  alu = sum;
      OP_SUB:  alu = dif;
      OP_OR:   alu = xa | xb;
      OP_AND:  alu = xa & xb;
      OP_XOR:  alu = xa ^ xb;
`ifdef SIMD_ALU_SAT_EN
      OP_SADD: alu = sum[DATA_W] ? {1'b0, {DATA_W{1'b1}}} : sum;
      OP_SSUB: alu = dif[DATA_W] ? '0 : dif;
`endif
      default: alu = '0;
    endcase
  endfunction

  // Control state. Statement order matters: a retire clearing rdy on the same
  // slot as a wake must win, and an alloc'd slot is invalid pre-edge so any
  // wake aimed at it is dropped by the e_vld qualifier.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_vld     <= '0;
      e_rdy     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      if (wake && e_vld[wake_idx]) e_rdy[wake_idx] <= 1'b1;
      if (alloc) begin
        e_vld[tail] <= 1'b1;
        e_rdy[tail] <= 1'b0;
        tail        <= tail + IDX_W'(1);
      end
      res_valid <= retire;
      if (retire) begin
        res_data    <= alu(e_op[head], e_a[head], e_b[head]);
        res_idx     <= head;
        e_vld[head] <= 1'b0;
        e_rdy[head] <= 1'b0;
        head        <= head + IDX_W'(1);
      end
      case ({alloc, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Payload needs no reset: it is only read behind e_vld.
  always_ff @(posedge clk) begin
    if (alloc) begin
      e_op[tail] <= alloc_op;
      e_a[tail]  <= alloc_a;
      e_b[tail]  <= alloc_b;
    end
  end

endmodule

// File: rtl/simd_rs_cluster.sv
// Purpose: multi-lane SIMD ALU; steers one instruction per cycle round-robin into per-lane RS.
// Latency: accept -> RS same edge; wake at edge E -> res_valid after edge E+1.
// Backpressure: in_ready drops only when every lane RS is full (a lane freeing this cycle is not eligible).
// Ports: in_* instruction handshake, issue_lane/issue_idx report the slot (wake tag) taken;
//        wake_valid/wake_idx per-lane wake; res_valid/res_data/res_idx per-lane packed results.
// Config: SIMD_ALU_SAT_EN enables saturating opcodes inside each lane.
module simd_rs_cluster import simd_pkg::*; #(
  parameter int LANES    = 4,
  parameter int RS_DEPTH = 4,
  parameter int DATA_W   = 8,
  parameter int LANE_W   = $clog2(LANES),
  parameter int IDX_W    = $clog2(RS_DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OP_W-1:0]             in_opcode,
  input  logic [DATA_W-1:0]           in_a,
  input  logic [DATA_W-1:0]           in_b,
  output logic [LANE_W-1:0]           issue_lane,
  output logic [IDX_W-1:0]            issue_idx,
  input  logic [LANES-1:0]            wake_valid,
  input  logic [LANES*IDX_W-1:0]      wake_idx,
  output logic [LANES-1:0]            res_valid,
  output logic [LANES*(DATA_W+1)-1:0] res_data,
  output logic [LANES*IDX_W-1:0]      res_idx
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RS_DEPTH);

  logic [LANE_W-1:0] rr_ptr;
  logic [LANE_W-1:0] chosen;
  logic              any_free;
  logic [LANES-1:0]  lane_free;
  logic [LANES-1:0]  lane_alloc;
  logic [IDX_W-1:0]  lane_tail  [LANES];
  logic [CNT_W-1:0]  lane_count [LANES];

  // Priority search starting at rr_ptr; LANES is a power of two so the
  // LANE_W-bit add wraps modulo LANES for free.
  always_comb begin
    chosen   = rr_ptr;
    any_free = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (!any_free && lane_free[rr_ptr + LANE_W'(k)]) begin
        chosen   = rr_ptr + LANE_W'(k);
        any_free = 1'b1;
      end
    end
  end

  assign in_ready   = any_free;
  assign issue_lane = chosen;
  assign issue_idx  = lane_tail[chosen];

  always_ff @(posedge clk) begin
    if (reset)                     rr_ptr <= '0;
    else if (in_valid && in_ready) rr_ptr <= chosen + LANE_W'(1);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_free[g]  = (lane_count[g] != CNT_FULL);
    assign lane_alloc[g] = in_valid && in_ready && (chosen == LANE_W'(g));

    simd_rs_lane #(
      .RS_DEPTH (RS_DEPTH),
      .DATA_W   (DATA_W),
      .IDX_W    (IDX_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .alloc     (lane_alloc[g]),
      .alloc_op  (in_opcode),
      .alloc_a   (in_a),
      .alloc_b   (in_b),
      .wake      (wake_valid[g]),
      .wake_idx  (wake_idx[g*IDX_W +: IDX_W]),
      .tail      (lane_tail[g]),
      .count     (lane_count[g]),
      .res_valid (res_valid[g]),
      .res_data  (res_data[g*(DATA_W+1) +: DATA_W+1]),
      .res_idx   (res_idx[g*IDX_W +: IDX_W])
    );
  end

endmodule
